// File: rtl/package_settings.sv
// Project-wide data-path settings shared by the signal-processing blocks.
//   SIZE_FILTER_DATA : width of the signed shaped-filter samples and of the
//                      trigger threshold that is compared against them.
package package_settings;

   localparam int SIZE_FILTER_DATA = 16;

endpackage : package_settings

// File: rtl/peak_parameters.sv
// Defaults and shared types for the filter peak detector.
//   MIN_WIDTH_DEFAULT : shortest over-threshold run accepted as a pulse
//   MAX_WIDTH_DEFAULT : run length at which a pulse is flagged as pile-up
//   HOLDOFF_DEFAULT   : dead time, in cycles, after a pulse is emitted
//   peak_state_t      : pulse-tracking FSM states
package peak_parameters;

   localparam int MIN_WIDTH_DEFAULT = 4;
   localparam int MAX_WIDTH_DEFAULT = 64;
   localparam int HOLDOFF_DEFAULT   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ABOVE = 2'd1,
      HOLD  = 2'd2
   } peak_state_t;

endpackage : peak_parameters

// File: rtl/peak_out_slot.sv
// Single-entry output register with a valid/ready handshake, plus a
// saturating count of events that arrived while the slot was occupied.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   emit              : a finished pulse is presented this cycle
//   emit_amplitude    : pulse maximum to store
//   emit_time         : timestamp of the first maximum sample
//   emit_pileup       : pulse reached the pile-up width
//   peak_ready        : consumer accepts the pending event
//   peak_valid        : an event is held in the slot
//   peak_amplitude    : stored amplitude
//   peak_time         : stored timestamp
//   peak_pileup       : stored pile-up flag
//   dropped_count     : events discarded because the slot was full
module peak_out_slot
   import package_settings::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        emit,
   input  logic [SIZE_FILTER_DATA-1:0] emit_amplitude,
   input  logic [31:0]                 emit_time,
   input  logic                        emit_pileup,
   input  logic                        peak_ready,
   output logic                        peak_valid,
   output logic [SIZE_FILTER_DATA-1:0] peak_amplitude,
   output logic [31:0]                 peak_time,
   output logic                        peak_pileup,
   output logic [15:0]                 dropped_count
);

   logic slot_busy;
   logic accept;

   assign accept    = peak_valid && peak_ready;
   // The slot is only "full" for a new event if the current one is not
   // leaving on this very edge; an accepted slot can be refilled at once.
   assign slot_busy = peak_valid && !peak_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_valid     <= 1'b0;
         peak_amplitude <= '0;
         peak_time      <= '0;
         peak_pileup    <= 1'b0;
         dropped_count  <= '0;
      end else begin
         if (emit) begin
            if (slot_busy) begin
               if (dropped_count != 16'hFFFF) begin
                  dropped_count <= dropped_count + 16'd1;
               end
            end else begin
               peak_valid     <= 1'b1;
               peak_amplitude <= emit_amplitude;
               peak_time      <= emit_time;
               peak_pileup    <= emit_pileup;
            end
         end else if (accept) begin
            peak_valid <= 1'b0;
         end
      end
   end

endmodule : peak_out_slot

// File: rtl/filter_peak_detector.sv
// Peak detector for a shaped-filter sample stream. A pulse is a run of
// samples strictly above the threshold; for runs of at least MIN_WIDTH
// samples the maximum, the timestamp of its first occurrence and a pile-up
// flag are handed to a single-entry output slot. After each emitted pulse
// the detector is blind for HOLDOFF cycles.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   filter_data     : signed sample, one per clock
//   threshold       : signed trigger level
//   peak_ready      : consumer accepts the pending event
//   peak_valid      : event pending
//   peak_amplitude  : maximum sample of the pulse
//   peak_time       : timestamp of the first sample equal to the maximum
//   peak_pileup     : pulse width reached MAX_WIDTH
//   dropped_count   : events lost because the slot was full (saturating)
module filter_peak_detector
   import package_settings::*;
   import peak_parameters::*;
#(
   parameter int MIN_WIDTH = MIN_WIDTH_DEFAULT,
   parameter int MAX_WIDTH = MAX_WIDTH_DEFAULT,
   parameter int HOLDOFF   = HOLDOFF_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   input  logic [SIZE_FILTER_DATA-1:0] threshold,
   input  logic                        peak_ready,
   output logic                        peak_valid,
   output logic [SIZE_FILTER_DATA-1:0] peak_amplitude,
   output logic [31:0]                 peak_time,
   output logic                        peak_pileup,
   output logic [15:0]                 dropped_count
);

   localparam int WIDTH_W = $clog2(MAX_WIDTH + 1);
   localparam int HOLD_W  = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;

   localparam logic [WIDTH_W-1:0] WIDTH_ONE = WIDTH_W'(1);
   localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_WIDTH);
   localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_WIDTH);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

   peak_state_t                 state;
   peak_state_t                 state_next;
   logic [31:0]                 timestamp;
   logic [WIDTH_W-1:0]          width;
   logic [WIDTH_W-1:0]          width_next;
   logic [SIZE_FILTER_DATA-1:0] max_value;
   logic [SIZE_FILTER_DATA-1:0] max_next;
   logic [31:0]                 max_time;
   logic [31:0]                 max_time_next;
   logic                        pileup;
   logic                        pileup_next;
   logic [HOLD_W-1:0]           hold_count;
   logic [HOLD_W-1:0]           hold_next;
   logic                        above;
   logic                        emit;

   assign above = $signed(filter_data) > $signed(threshold);

   // Free-running timestamp; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timestamp <= '0;
      end else begin
         timestamp <= timestamp + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         width      <= '0;
         max_value  <= '0;
         max_time   <= '0;
         pileup     <= 1'b0;
         hold_count <= '0;
      end else begin
         state      <= state_next;
         width      <= width_next;
         max_value  <= max_next;
         max_time   <= max_time_next;
         pileup     <= pileup_next;
         hold_count <= hold_next;
      end
   end

   always_comb begin
      state_next    = state;
      width_next    = width;
      max_next      = max_value;
      max_time_next = max_time;
      pileup_next   = pileup;
      hold_next     = hold_count;
      emit          = 1'b0;

      case (state)
         IDLE: begin
            if (above) begin
               state_next    = ABOVE;
               width_next    = WIDTH_ONE;
               max_next      = filter_data;
               max_time_next = timestamp;
               pileup_next   = (WIDTH_ONE >= MAX_W);
            end
         end

         ABOVE: begin
            if (above) begin
               if (width != MAX_W) begin
                  width_next = width + WIDTH_ONE;
               end
               if (width_next == MAX_W) begin
                  pileup_next = 1'b1;
               end
               // Strictly greater only: an equal sample keeps the earlier time.
               if ($signed(filter_data) > $signed(max_value)) begin
                  max_next      = filter_data;
                  max_time_next = timestamp;
               end
            end else if (width >= MIN_W) begin
               // The terminating sample is at or below threshold, so it can
               // never be the maximum; the registered max is the event.
               emit       = 1'b1;
               state_next = HOLD;
               hold_next  = HOLD_LOAD;
            end else begin
               state_next = IDLE;
            end
         end

         HOLD: begin
            if (hold_count == '0) begin
               state_next = IDLE;
            end else begin
               hold_next = hold_count - HOLD_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   peak_out_slot u_slot (
      .clk            (clk),
      .reset          (reset),
      .emit           (emit),
      .emit_amplitude (max_value),
      .emit_time      (max_time),
      .emit_pileup    (pileup),
      .peak_ready     (peak_ready),
      .peak_valid     (peak_valid),
      .peak_amplitude (peak_amplitude),
      .peak_time      (peak_time),
      .peak_pileup    (peak_pileup),
      .dropped_count  (dropped_count)
   );

endmodule : filter_peak_detector

// File: tb/tb_filter_peak_detector.sv
// Self-checking bench for filter_peak_detector: directed scenarios followed
// by randomized bursts, all compared against a pulse-list reference model.
module tb_filter_peak_detector;

   localparam int DW        = 16;
   localparam int MIN_WIDTH = 4;
   localparam int MAX_WIDTH = 64;
   localparam int HOLDOFF   = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] filter_data;
   logic [DW-1:0] threshold;
   logic          peak_ready;
   logic          peak_valid;
   logic [DW-1:0] peak_amplitude;
   logic [31:0]   peak_time;
   logic          peak_pileup;
   logic [15:0]   dropped_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the current pulse as a list of samples with its start
   // time, a dead-time countdown, and the output slot contents.
   int          m_ts;
   int          m_pulse[$];
   int          m_start;
   int          m_ignore;
   bit          m_valid;
   logic [DW-1:0] m_amp;
   logic [31:0] m_time;
   bit          m_pile;
   int          m_drop;
   int          m_thr;

   filter_peak_detector dut (
      .clk            (clk),
      .reset          (reset),
      .filter_data    (filter_data),
      .threshold      (threshold),
      .peak_ready     (peak_ready),
      .peak_valid     (peak_valid),
      .peak_amplitude (peak_amplitude),
      .peak_time      (peak_time),
      .peak_pileup    (peak_pileup),
      .dropped_count  (dropped_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ts     = 0;
      m_pulse  = {};
      m_start  = 0;
      m_ignore = 0;
      m_valid  = 0;
      m_amp    = '0;
      m_time   = '0;
      m_pile   = 0;
      m_drop   = 0;
   endtask

   // One clock edge of the reference model.
   task automatic model_edge(input int sample, input bit rdy);
      bit          accept;
      bit          ev;
      logic [DW-1:0] ev_amp;
      logic [31:0] ev_time;
      bit          ev_pile;
      int          best;
      int          best_idx;
      accept = m_valid && rdy;
      ev = 0;
      ev_amp = '0;
      ev_time = '0;
      ev_pile = 0;
      if (m_ignore > 0) begin
         m_ignore--;
      end else if (m_pulse.size() > 0) begin
         if (sample > m_thr) begin
            m_pulse.push_back(sample);
         end else begin
            if (m_pulse.size() >= MIN_WIDTH) begin
               best = m_pulse[0];
               best_idx = 0;
               foreach (m_pulse[k]) begin
                  if (m_pulse[k] > best) begin
                     best = m_pulse[k];
                     best_idx = k;
                  end
               end
               ev = 1;
               ev_amp = DW'(best);
               ev_time = 32'(m_start + best_idx);
               ev_pile = (m_pulse.size() >= MAX_WIDTH);
               m_ignore = HOLDOFF;
            end
            m_pulse = {};
         end
      end else if (sample > m_thr) begin
         m_pulse.push_back(sample);
         m_start = m_ts;
      end
      if (ev) begin
         if (m_valid && !accept) begin
            if (m_drop < 65535) m_drop++;
         end else begin
            m_valid = 1;
            m_amp = ev_amp;
            m_time = ev_time;
            m_pile = ev_pile;
         end
      end else if (accept) begin
         m_valid = 0;
      end
      m_ts++;
   endtask

   task automatic compare(input string tag);
      check({tag, "_valid"}, 32'(peak_valid), 32'(m_valid));
      if (m_valid) begin
         check({tag, "_amp"}, 32'(peak_amplitude), 32'(m_amp));
         check({tag, "_time"}, peak_time, m_time);
         check({tag, "_pileup"}, 32'(peak_pileup), 32'(m_pile));
      end
      check({tag, "_dropped"}, 32'(dropped_count), 32'(m_drop));
   endtask

   // Drive one sample, clock it, update the model, then compare.
   task automatic step(input int sample, input bit rdy, input string tag);
      filter_data = DW'(sample);
      peak_ready  = rdy;
      @(posedge clk);
      model_edge(sample, rdy);
      #1;
      compare(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(peak_valid), 32'd0);
      check({tag, "_amp"}, 32'(peak_amplitude), 32'd0);
      check({tag, "_time"}, peak_time, 32'd0);
      check({tag, "_pileup"}, 32'(peak_pileup), 32'd0);
      check({tag, "_dropped"}, 32'(dropped_count), 32'd0);
   endtask

   task automatic set_threshold(input int t);
      threshold = DW'(t);
      m_thr = t;
   endtask

   initial begin
      int t_mark;
      int len;
      int lvl;
      bit up;
      reset = 1'b1;
      filter_data = '0;
      peak_ready = 1'b1;
      set_threshold(100);
      model_reset();
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic pulse: 0,150,300,250,120,50 -> amplitude 300 at time 2.
      step(0, 1, "basic");
      step(150, 1, "basic");
      step(300, 1, "basic");
      step(250, 1, "basic");
      step(120, 1, "basic");
      check("basic_no_early_valid", 32'(peak_valid), 32'd0);
      step(50, 1, "basic");
      check("basic_emit_valid", 32'(peak_valid), 32'd1);
      check("basic_emit_amp", 32'(peak_amplitude), 32'd300);
      check("basic_emit_time", peak_time, 32'd2);
      check("basic_emit_pileup", 32'(peak_pileup), 32'd0);
      step(0, 1, "basic");
      check("basic_one_cycle", 32'(peak_valid), 32'd0);
      for (int i = 0; i < 10; i++) step(0, 1, "basic_tail");

      // Short run of three: discarded; a pulse right after is detected.
      step(200, 1, "short");
      step(200, 1, "short");
      step(200, 1, "short");
      step(0, 1, "short");
      t_mark = m_ts;
      step(210, 1, "short_next");
      step(220, 1, "short_next");
      step(205, 1, "short_next");
      step(201, 1, "short_next");
      step(0, 1, "short_next");
      check("short_next_valid", 32'(peak_valid), 32'd1);
      check("short_next_time", peak_time, 32'(t_mark + 1));
      for (int i = 0; i < 10; i++) step(0, 1, "short_tail");

      // Long run: pile-up.
      t_mark = m_ts;
      for (int i = 0; i < 70; i++) step(500, 1, "pileup");
      step(0, 1, "pileup");
      check("pileup_flag", 32'(peak_pileup), 32'd1);
      check("pileup_amp", 32'(peak_amplitude), 32'd500);
      check("pileup_time", peak_time, 32'(t_mark));
      for (int i = 0; i < 10; i++) step(0, 1, "pileup_tail");

      // Full slot: second event dropped, first kept, then accepted.
      step(150, 0, "drop_a");
      step(300, 0, "drop_a");
      step(250, 0, "drop_a");
      step(200, 0, "drop_a");
      step(0, 0, "drop_a");
      for (int i = 0; i < 10; i++) step(0, 0, "drop_gap");
      for (int i = 0; i < 5; i++) step(400, 0, "drop_b");
      step(0, 0, "drop_b");
      check("drop_count", 32'(dropped_count), 32'd1);
      check("drop_kept_amp", 32'(peak_amplitude), 32'd300);
      step(0, 1, "drop_accept");
      check("drop_accept_valid", 32'(peak_valid), 32'd0);
      for (int i = 0; i < 10; i++) step(0, 1, "drop_tail");

      // Pulse ending inside HOLD is ignored.
      for (int i = 0; i < 4; i++) step(180, 1, "hold_first");
      step(0, 1, "hold_first");
      step(200, 1, "hold_ign");
      step(200, 1, "hold_ign");
      step(0, 1, "hold_ign");
      for (int i = 0; i < 12; i++) step(0, 1, "hold_tail");
      check("hold_no_event", 32'(peak_valid), 32'd0);
      check("hold_drop_same", 32'(dropped_count), 32'd1);

      // Asynchronous reset mid-pulse, with an event pending.
      for (int i = 0; i < 4; i++) step(180, 0, "rst_pend");
      step(0, 0, "rst_pend");
      for (int i = 0; i < 9; i++) step(0, 0, "rst_pend");
      step(200, 0, "rst_mid");
      step(200, 0, "rst_mid");
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("rst_async");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(400, 1, "tie");
      step(400, 1, "tie");
      step(300, 1, "tie");
      step(300, 1, "tie");
      step(0, 1, "tie");
      check("tie_time", peak_time, 32'd0);
      check("tie_amp", 32'(peak_amplitude), 32'd400);
      check("tie_dropped", 32'(dropped_count), 32'd0);
      for (int i = 0; i < 10; i++) step(0, 1, "tie_tail");

      // Randomized bursts, threshold changed only while quiescent.
      for (int seg = 0; seg < 6; seg++) begin
         set_threshold(int'($urandom_range(20, 300)));
         for (int b = 0; b < 40; b++) begin
            up  = ($urandom_range(0, 1) == 1);
            len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 70))
                                               : int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
               if (up) lvl = m_thr + 1 + int'($urandom_range(0, 3)) * 50;
               else    lvl = m_thr - int'($urandom_range(0, 700));
               step(lvl, ($urandom_range(0, 3) != 0), "rand");
            end
         end
         for (int i = 0; i < 20; i++) step(0, 1, "rand_quiet");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_filter_peak_detector

// File: doc/filter_peak_detector.md
FILTER_PEAK_DETECTOR -- requirements
Module: filter_peak_detector

Interface
REQ-001 Parameter MIN_WIDTH, default 4: minimum over-threshold width, in samples, for a valid pulse.
REQ-002 Parameter MAX_WIDTH, default 64: over-threshold width, in samples, at which a pulse is flagged pile-up.
REQ-003 Parameter HOLDOFF, default 8: cycles spent in HOLD after a pulse ends, before re-arming.
REQ-004 Port clk, input, 1: single clock; every register is clocked on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port filter_data, input, SIZE_FILTER_DATA: signed two's-complement shaped sample from the upstream shaping filter, one sample per clk.
REQ-007 Port threshold, input, SIZE_FILTER_DATA: signed trigger level, static while armed.
REQ-008 Port peak_ready, input, 1: consumer accepts the pending event.
REQ-009 Port peak_valid, output, 1: an event is pending on the outputs.
REQ-010 Port peak_amplitude, output, SIZE_FILTER_DATA: maximum sample within the pulse.
REQ-011 Port peak_time, output, 32: timestamp of the first sample equal to that maximum.
REQ-012 Port peak_pileup, output, 1: the pulse reached MAX_WIDTH.
REQ-013 Port dropped_count, output, 16: number of events lost because the output slot was full.

Function
REQ-014 A 32-bit free-running timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-015 The FSM SHALL have exactly three states: IDLE, ABOVE and HOLD.
REQ-016 IDLE: when signed filter_data > threshold, go to ABOVE and load max=filter_data, max_time=timestamp, width=1.
REQ-017 ABOVE, while filter_data > threshold: width increments; max and max_time update only on a strictly greater sample (ties keep the earlier time).
REQ-018 width SHALL saturate at MAX_WIDTH, and a pileup flag SHALL set when width reaches MAX_WIDTH.
REQ-019 ABOVE, on filter_data <= threshold with width >= MIN_WIDTH: emit an event and go to HOLD with the holdoff counter at HOLDOFF-1.
REQ-020 ABOVE, on filter_data <= threshold with width < MIN_WIDTH: discard the pulse (noise) and go directly to IDLE.
REQ-021 HOLD: decrement the holdoff counter each cycle, ignore filter_data, and return to IDLE when the counter is 0.
REQ-022 Emit latency: peak_valid and the event fields SHALL be registered on the same edge that samples the terminating sample.
REQ-023 Output is a single-entry slot with valid/ready handshake: the fields hold stable while peak_valid=1, and peak_valid clears on the edge where peak_valid and peak_ready are both 1.
REQ-024 Emit while the slot is full and not being accepted that cycle: discard the new event, keep the old one, and increment dropped_count, saturating at 0xFFFF.
REQ-025 Emit in the same cycle as acceptance of the old event: load the new event, and peak_valid stays 1.
REQ-026 All sample/threshold comparisons SHALL be signed; there is no width extension, as the inputs share SIZE_FILTER_DATA.

Reset
REQ-027 Reset SHALL force the FSM to IDLE and clear to 0: the timestamp, width, max, max_time, holdoff counter, peak_valid, peak_amplitude, peak_time, peak_pileup and dropped_count.
REQ-028 Reset asserted mid-pulse or with an event pending SHALL lose that pulse or event without counting it as dropped.
REQ-029 The first edge after reset release SHALL evaluate filter_data from IDLE with timestamp=0.

Structure
REQ-030 SIZE_FILTER_DATA SHALL come from package_settings.
REQ-031 MIN_WIDTH, MAX_WIDTH and HOLDOFF defaults, plus the FSM state enum typedef, SHALL live in a new package peak_parameters.
REQ-032 One sub-module, peak_out_slot, SHALL contain the single-entry handshake register and the dropped_count saturating counter.

Verification
REQ-033 Reset release, threshold=100, samples 0,150,300,250,120,50, ready=1 -> one event with amplitude=300, time=2, pileup=0, peak_valid high for exactly 1 cycle.
REQ-034 Three samples of 200, then 0 (width 3 < MIN_WIDTH=4) -> no event, FSM back in IDLE, and a new pulse one cycle later is detected.
REQ-035 70 consecutive samples of 500, then 0 -> event with amplitude=500, time at the first 500, pileup=1.
REQ-036 ready=0, then two valid pulses separated by more than HOLDOFF -> first event held unchanged, dropped_count=1; then ready=1 -> first event accepted and peak_valid=0.
REQ-037 Pulse ending 3 cycles after a prior emit (inside HOLD) -> ignored, no event, dropped_count unchanged.
REQ-038 Reset asserted mid-pulse for 1 cycle -> all outputs 0 immediately (asynchronous), no event emitted; equal peaks 400,400 -> earlier timestamp reported.
